multicycle_rv_core: RTL

- Parametrised successor to the single-cycle top level: a multi-cycle RV32I-subset core driven by an explicit state machine.
- Owns the PC, the instruction register, an internal register file, immediate generation and the ALU.
- Talks to external instruction and data memories through ready-handshake ports, so memories may insert wait states.
- Sits as the CPU core beneath the system top; halts cleanly on illegal or unsupported conditions.

---
 rtl/multicycle_rv_core.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_rv_core.sv
// Multi-cycle RV32I-subset core (RV32E when NUM_REGS=16) with handshake memory ports.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   imem_req/addr/ready/rdata       instruction fetch (addr = PC, held until ready)
//   dmem_req/we/addr/wdata/ready/rdata  word data access (held until ready)
//   pc_out, retire, halted          current PC, commit pulse, stopped flag
// NUM_REGS must be 16 or 32.
module multicycle_rv_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] pc_out,
    output logic        retire,
    output logic        halted
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned RA_W = (NUM_REGS == 16) ? 4 : 5;
    localparam logic [5:0]  NREG = 6'(NUM_REGS);

    localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63, OP_LOAD = 7'h03, OP_STORE = 7'h23;
    localparam logic [6:0] OP_IMM = 7'h13, OP_REG = 7'h33;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d, ir_q, ir_d, res_q, res_d, npc_q, npc_d;
    logic [XLEN-1:0]   daddr_q, daddr_d, dwdata_q, dwdata_d;
    logic              dwe_q, dwe_d;
    logic              ireq_q, ireq_d, dreq_q, dreq_d, retire_q, retire_d, halted_q, halted_d;
    logic [XLEN-1:0]   rf_q [NUM_REGS];
    logic              rf_we;
    logic [XLEN-1:0]   wb_data;

    // Instruction fields
    logic [6:0] opcode, f7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign f3     = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign f7     = ir_q[31:25];

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u = {ir_q[31:12], 12'h000};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    // Decode: legality, which register fields are live, immediate format
    logic legal, use_rs1, use_rs2, use_rd, reg_bad;
    always_comb begin
        legal   = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        imm     = '0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin legal = 1'b1; use_rd = 1'b1; imm = imm_u; end
            OP_JAL:    begin legal = 1'b1; use_rd = 1'b1; imm = imm_j; end
            OP_JALR:   begin legal = (f3 == 3'd0); use_rs1 = 1'b1; use_rd = 1'b1; imm = imm_i; end
            OP_BRANCH: begin legal = (f3 != 3'd2) && (f3 != 3'd3); use_rs1 = 1'b1; use_rs2 = 1'b1; imm = imm_b; end
            OP_LOAD:   begin legal = (f3 == 3'd2); use_rs1 = 1'b1; use_rd = 1'b1; imm = imm_i; end
            OP_STORE:  begin legal = (f3 == 3'd2); use_rs1 = 1'b1; use_rs2 = 1'b1; imm = imm_s; end
            OP_IMM: begin
                use_rs1 = 1'b1; use_rd = 1'b1; imm = imm_i;
                if (f3 == 3'd1)      legal = (f7 == 7'h00);
                else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
                else                 legal = 1'b1;
            end
            OP_REG: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
                legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
            end
            default: legal = 1'b0;
        endcase
    end
    assign reg_bad = (use_rs1 && ({1'b0, rs1} >= NREG)) || (use_rs2 && ({1'b0, rs2} >= NREG))
                   || (use_rd && ({1'b0, rd} >= NREG));

    // x0 is never written, so entry 0 always reads zero
    logic [XLEN-1:0] rs1_v, rs2_v, b_op, alu;
    logic [4:0]      shamt;
    assign rs1_v = rf_q[rs1[RA_W-1:0]];
    assign rs2_v = rf_q[rs2[RA_W-1:0]];
    assign b_op  = (opcode == OP_REG) ? rs2_v : imm;
    assign shamt = b_op[4:0];

    always_comb begin
        case (f3)
            3'd0:    alu = ((opcode == OP_REG) && f7[5]) ? rs1_v - b_op : rs1_v + b_op;
            3'd1:    alu = rs1_v << shamt;
            3'd2:    alu = {31'd0, $signed(rs1_v) < $signed(b_op)};
            3'd3:    alu = {31'd0, rs1_v < b_op};
            3'd4:    alu = rs1_v ^ b_op;
            3'd5:    alu = f7[5] ? $unsigned($signed(rs1_v) >>> shamt) : rs1_v >> shamt;
            3'd6:    alu = rs1_v | b_op;
            default: alu = rs1_v & b_op;
        endcase
    end

    logic taken;
    always_comb begin
        case (f3)
            3'd0:    taken = (rs1_v == rs2_v);
            3'd1:    taken = (rs1_v != rs2_v);
            3'd4:    taken = $signed(rs1_v) < $signed(rs2_v);
            3'd5:    taken = $signed(rs1_v) >= $signed(rs2_v);
            3'd6:    taken = rs1_v < rs2_v;
            3'd7:    taken = rs1_v >= rs2_v;
            default: taken = 1'b0;
        endcase
    end

    // Execute: result, next PC and the misalignment fault
    logic [XLEN-1:0] pc_plus4, pc_imm, rs1_imm, exe_res, exe_npc;
    logic            exe_bad, is_mem;
    assign pc_plus4 = pc_q + 32'd4;
    assign pc_imm   = pc_q + imm;
    assign rs1_imm  = rs1_v + imm;
    assign is_mem   = (opcode == OP_LOAD) || (opcode == OP_STORE);
    always_comb begin
        exe_res = alu;
        exe_npc = pc_plus4;
        exe_bad = 1'b0;
        case (opcode)
            OP_LUI:    exe_res = imm;
            OP_AUIPC:  exe_res = pc_imm;
            OP_JAL:    begin exe_res = pc_plus4; exe_npc = pc_imm; end
            OP_JALR:   begin exe_res = pc_plus4; exe_npc = {rs1_imm[31:1], 1'b0}; end
            OP_BRANCH: if (taken) exe_npc = pc_imm;
            OP_LOAD, OP_STORE: begin exe_res = rs1_imm; exe_bad = (rs1_imm[1:0] != 2'b00); end
            default:   exe_res = alu;
        endcase
        if (exe_npc[1:0] != 2'b00) exe_bad = 1'b1;
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        res_d    = res_q;
        npc_d    = npc_q;
        daddr_d  = daddr_q;
        dwdata_d = dwdata_q;
        dwe_d    = dwe_q;
        rf_we    = 1'b0;
        wb_data  = res_q;
        case (state_q)
            S_FETCH: if (ireq_q && imem_ready) begin
                ir_d    = imem_rdata;
                state_d = S_DECODE;
            end
            S_DECODE: state_d = (legal && !reg_bad) ? S_EXEC : S_HALT;
            S_EXEC: begin
                if (exe_bad) begin
                    state_d = S_HALT;
                end else begin
                    res_d   = exe_res;
                    npc_d   = exe_npc;
                    state_d = S_WB;
                    if (is_mem) begin
                        daddr_d  = exe_res;
                        dwdata_d = rs2_v;
                        dwe_d    = (opcode == OP_STORE);
                        state_d  = S_MEM;
                    end
                end
            end
            S_MEM: if (dreq_q && dmem_ready) begin
                if (!dwe_q) res_d = dmem_rdata;
                state_d = S_WB;
            end
            S_WB: begin
                rf_we   = use_rd && (rd != 5'd0);
                pc_d    = npc_q;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
        ireq_d   = (state_d == S_FETCH);
        dreq_d   = (state_d == S_MEM);
        retire_d = (state_d == S_WB);
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            res_q    <= '0;
            npc_q    <= '0;
            daddr_q  <= '0;
            dwdata_q <= '0;
            dwe_q    <= 1'b0;
            ireq_q   <= 1'b0;
            dreq_q   <= 1'b0;
            retire_q <= 1'b0;
            halted_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            res_q    <= res_d;
            npc_q    <= npc_d;
            daddr_q  <= daddr_d;
            dwdata_q <= dwdata_d;
            dwe_q    <= dwe_d;
            ireq_q   <= ireq_d;
            dreq_q   <= dreq_d;
            retire_q <= retire_d;
            halted_q <= halted_d;
            if (rf_we) rf_q[rd[RA_W-1:0]] <= wb_data;
        end
    end

    assign imem_req   = ireq_q;
    assign imem_addr  = pc_q;
    assign dmem_req   = dreq_q;
    assign dmem_we    = dwe_q;
    assign dmem_addr  = daddr_q;
    assign dmem_wdata = dwdata_q;
    assign pc_out     = pc_q;
    assign retire     = retire_q;
    assign halted     = halted_q;
endmodule
